// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings and FSM states shared by the multiply/divide unit.
package mdu_pkg;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
endpackage

// File: rtl/div_core.sv
// div_core: radix-2 restoring divider on magnitudes with sign fix-up.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic             sgn_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, quo_q, den_q, rem_d, quo_d;
    logic [WIDTH:0]   rem_sh, diff;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, nq_q, nr_q, fit, a_neg, b_neg;

    assign a_neg  = sgn_i & a_i[WIDTH-1];
    assign b_neg  = sgn_i & b_i[WIDTH-1];
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, den_q};
    assign fit    = !diff[WIDTH];
    assign rem_d  = fit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_d  = {quo_q[WIDTH-2:0], fit};
    // Results are taken from the final iteration's next values, saving a cycle.
    assign done_o = busy_q && cnt_q == CW'(WIDTH - 1);
    assign q_o    = nq_q ? -quo_d : quo_d;
    assign r_o    = nr_q ? -rem_d : rem_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            nq_q   <= 1'b0;
            nr_q   <= 1'b0;
        end else if (start_i) begin
            rem_q  <= '0;
            quo_q  <= a_neg ? -a_i : a_i;
            den_q  <= b_neg ? -b_i : b_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            // Divide by zero keeps the all-ones quotient unnegated.
            nq_q   <= (a_neg ^ b_neg) && |b_i;
            nr_q   <= a_neg;
        end else if (annul_i || done_o) begin
            busy_q <= 1'b0;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: MIPS-style HI/LO multiply/divide unit with pipeline stall
// and annul; inline multiplier and FSM, iterative divider in div_core.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             annul_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, ma_q, ma_d, mb_q, mb_d, mx, my, dq, dr;
    logic [2*WIDTH-1:0] prod;
    logic [1:0]         cnt_q, cnt_d;
    logic               ms_q, ms_d, msx, accept, is_mul, is_div, ddone;

    assign accept  = rst && state_q == S_IDLE && start_i && !annul_i;
    assign is_mul  = op_i == OP_MULT || op_i == OP_MULTU;
    assign is_div  = op_i == OP_DIV || op_i == OP_DIVU;
    assign stall_o = (accept && (is_mul || is_div)) || state_q == S_MUL || state_q == S_DIV;
    assign ready_o = state_q == S_DONE;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    // Single-cycle multiply reads the live operands; otherwise the captured ones.
    assign mx   = MUL_LAT == 1 ? a_i : ma_q;
    assign my   = MUL_LAT == 1 ? b_i : mb_q;
    assign msx  = MUL_LAT == 1 ? op_i == OP_MULT : ms_q;
    assign prod = {{WIDTH{msx & mx[WIDTH-1]}}, mx} * {{WIDTH{msx & my[WIDTH-1]}}, my};

    div_core #(.WIDTH(WIDTH)) u_div (
        .clk    (clka),
        .rst_n  (rst),
        .start_i(accept && is_div),
        .annul_i(annul_i && state_q == S_DIV),
        .sgn_i  (op_i == OP_DIV),
        .a_i    (a_i),
        .b_i    (b_i),
        .q_o    (dq),
        .r_o    (dr),
        .done_o (ddone)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        ms_d    = ms_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (accept) begin
                if (is_mul) begin
                    ma_d  = a_i;
                    mb_d  = b_i;
                    ms_d  = op_i == OP_MULT;
                    cnt_d = '0;
                    if (MUL_LAT == 1) begin
                        {hi_d, lo_d} = prod;
                        state_d      = S_DONE;
                    end else begin
                        state_d = S_MUL;
                    end
                end else if (is_div) begin
                    state_d = S_DIV;
                end else if (op_i == OP_MTHI) begin
                    hi_d = a_i;
                end else if (op_i == OP_MTLO) begin
                    lo_d = a_i;
                end
            end
            S_MUL: if (annul_i) begin
                state_d = S_IDLE;
            end else if (cnt_q == 2'(MUL_LAT - 2)) begin
                {hi_d, lo_d} = prod;
                state_d      = S_DONE;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
            S_DIV: if (annul_i) begin
                state_d = S_IDLE;
            end else if (ddone) begin
                hi_d    = dr;
                lo_d    = dq;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            ms_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            ms_q    <= ms_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors against an arithmetic HI/LO model,
// with per-cycle output comparison and literal checks of key results.
module tb_mul_div_unit;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 2;

    logic              clka = 1'b0;
    logic              rst = 1'b0;
    logic              start_i = 1'b0;
    logic [2:0]        op_i = 3'd0;
    logic [WIDTH-1:0]  a_i = '0;
    logic [WIDTH-1:0]  b_i = '0;
    logic              annul_i = 1'b0;
    logic              stall_o, ready_o;
    logic [WIDTH-1:0]  hi_o, lo_o;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clka   (clka),
        .rst    (rst),
        .start_i(start_i),
        .op_i   (op_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .annul_i(annul_i),
        .stall_o(stall_o),
        .ready_o(ready_o),
        .hi_o   (hi_o),
        .lo_o   (lo_o)
    );

    always #5 clka = ~clka;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] op_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2, 3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (op == 3'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Model: edges remaining until the result lands, plus architectural HI/LO.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res = '0;
    int          m_rem = 0;
    bit          m_done = 0;

    always @(posedge clka or negedge rst) begin
        if (!rst) begin
            m_hi <= '0; m_lo <= '0; m_rem <= 0; m_done <= 0;
        end else begin
            m_done <= 0;
            if (m_rem > 0) begin
                if (annul_i) m_rem <= 0;
                else if (m_rem == 1) begin
                    m_rem <= 0; {m_hi, m_lo} <= m_res; m_done <= 1;
                end else m_rem <= m_rem - 1;
            end else if (!m_done && start_i && !annul_i) begin
                if (op_i < 3'd4) begin
                    if (op_i < 3'd2 && MUL_LAT == 1) begin
                        {m_hi, m_lo} <= op_res(op_i, a_i, b_i); m_done <= 1;
                    end else begin
                        m_res <= op_res(op_i, a_i, b_i);
                        m_rem <= op_i < 3'd2 ? MUL_LAT - 1 : WIDTH;
                    end
                end else if (op_i == 3'd4) m_hi <= a_i;
                else if (op_i == 3'd5) m_lo <= a_i;
            end
        end
    end

    always @(negedge clka) begin
        chk("cmp stall", 64'(stall_o),
            64'(rst && (m_rem > 0 || (!m_done && start_i && !annul_i && op_i < 3'd4))));
        chk("cmp ready", 64'(ready_o), 64'(m_done));
        chk("cmp hi", 64'(hi_o), 64'(m_hi));
        chk("cmp lo", 64'(lo_o), 64'(m_lo));
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after ready.
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int lat);
        int cyc = 0;
        bit seen = 0;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        while (!seen && cyc <= lat + 3) begin
            @(negedge clka);
            if (ready_o) seen = 1;
            else begin
                @(posedge clka); #1;
                start_i = 1'b0; a_i = $urandom; b_i = $urandom;
                cyc++;
            end
        end
        chk({nm, " latency"}, seen ? 64'(cyc) : 64'hFFFF, 64'(lat));
        chk({nm, " hi"}, 64'(hi_o), 64'(eh));
        chk({nm, " lo"}, 64'(lo_o), 64'(el));
        @(posedge clka); #1;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        start_i = 1'b1; op_i = op; a_i = v;
        @(posedge clka); #1;
        start_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int rdy;
        #12;
        chk("reset hi", 64'(hi_o), 64'd0);
        chk("reset lo", 64'(lo_o), 64'd0);
        chk("reset stall", 64'(stall_o), 64'd0);
        chk("reset ready", 64'(ready_o), 64'd0);
        @(posedge clka); #1;
        rst = 1'b1;
        do_op("divu 7/2", 3'd3, 32'h7, 32'h2, 32'h1, 32'h3, WIDTH + 1);
        do_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, WIDTH + 1);
        do_op("div min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, WIDTH + 1);
        do_op("mult -1*2", 3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, MUL_LAT);
        do_op("divu by 0", 3'd3, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, WIDTH + 1);
        do_op("div -7 by 0", 3'd2, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, WIDTH + 1);
        do_op("mult min*min", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_LAT);
        do_op("div 7/-2", 3'd2, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, WIDTH + 1);
        // Start with annul in IDLE, and an unused op code: neither is accepted.
        start_i = 1'b1; annul_i = 1'b1; op_i = 3'd0; a_i = 32'h5; b_i = 32'h5;
        @(negedge clka);
        chk("annul+start stall", 64'(stall_o), 64'd0);
        @(posedge clka); #1;
        annul_i = 1'b0; op_i = 3'd6;
        @(posedge clka); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clka);
        #1;
        chk("noop hi", 64'(hi_o), 64'h1);
        // Annulled divide after MTHI, then MTLO accepted in the next cycle.
        mt(3'd4, 32'hAAAA_5555);
        start_i = 1'b1; op_i = 3'd2; a_i = 32'd100; b_i = 32'd3;
        repeat (10) begin
            @(posedge clka); #1;
            start_i = 1'b0;
        end
        annul_i = 1'b1;
        @(negedge clka);
        chk("annul c10 stall", 64'(stall_o), 64'd1);
        @(posedge clka); #1;
        annul_i = 1'b0; start_i = 1'b1; op_i = 3'd5; a_i = 32'h0BAD_F00D;
        @(negedge clka);
        chk("annul c11 stall", 64'(stall_o), 64'd0);
        chk("annul c11 hi", 64'(hi_o), 64'hAAAA_5555);
        @(posedge clka); #1;
        start_i = 1'b0;
        rdy = 0;
        repeat (40) begin
            @(negedge clka);
            if (ready_o) rdy++;
        end
        chk("annul no ready", 64'(rdy), 64'd0);
        chk("mtlo lo", 64'(lo_o), 64'h0BAD_F00D);
        chk("annul keeps hi", 64'(hi_o), 64'hAAAA_5555);
        // Reset in cycle 5 of a divide.
        @(posedge clka); #1;
        start_i = 1'b1; op_i = 3'd3; a_i = 32'd50; b_i = 32'd7;
        repeat (5) begin
            @(posedge clka); #1;
            start_i = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("rst hi", 64'(hi_o), 64'd0);
        chk("rst lo", 64'(lo_o), 64'd0);
        chk("rst stall", 64'(stall_o), 64'd0);
        chk("rst ready", 64'(ready_o), 64'd0);
        rdy = 0;
        repeat (3) begin
            @(negedge clka);
            if (ready_o) rdy++;
        end
        chk("rst no ready", 64'(rdy), 64'd0);
        @(posedge clka); #1;
        rst = 1'b1;
        do_op("multu after rst", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, MUL_LAT);
        rdy = 0;
        repeat (40) begin
            @(negedge clka);
            if (ready_o) rdy++;
        end
        chk("no stray ready", 64'(rdy), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (even, >= 8).
REQ-002 SHALL have parameter MUL_LAT, default 2, multiply latency in cycles (1..4).
REQ-003 SHALL have port clka, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start_i, input, 1, request to accept the op on op_i this cycle.
REQ-006 SHALL have port op_i, input, 3, operation select: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port a_i, input, WIDTH, rs operand (dividend, multiplicand, MTHI/MTLO data).
REQ-008 SHALL have port b_i, input, WIDTH, rt operand (divisor, multiplier).
REQ-009 SHALL have port annul_i, input, 1, abort the in-flight operation.
REQ-010 SHALL have port stall_o, output, 1, pipeline stall request.
REQ-011 SHALL have port ready_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port hi_o, output, WIDTH, architectural HI register.
REQ-013 SHALL have port lo_o, output, WIDTH, architectural LO register.

Function
REQ-014 SHALL use a state machine with states IDLE, MUL, DIV and DONE.
REQ-015 SHALL accept start_i only in IDLE; start_i in any other state SHALL be ignored.
REQ-016 MTHI/MTLO accepted SHALL write a_i to hi_o/lo_o at that edge, with no stall, no ready_o, and the state remaining IDLE.
REQ-017 MULT/MULTU accepted SHALL register the operands, go to MUL, and produce the 2*WIDTH product {hi,lo}, signed for MULT and unsigned for MULTU.
REQ-018 DIV/DIVU SHALL use a radix-2 restoring divider of WIDTH iterations on operand magnitudes, then sign correction: quotient negative iff operand signs differ, remainder takes the dividend's sign.
REQ-019 Cycle numbering: acceptance cycle = 0; ready_o SHALL be high in cycle MUL_LAT (multiply) or cycle WIDTH+1 (divide), in state DONE.
REQ-020 HI/LO SHALL be updated at the edge entering DONE and visible during the ready_o cycle; DONE SHALL return to IDLE on the next edge.
REQ-021 stall_o SHALL be combinational: (IDLE & start_i & op is MULT/MULTU/DIV/DIVU) | state is MUL or DIV; it SHALL be low in DONE.
REQ-022 Divide by zero SHALL complete with normal latency, giving lo = all ones and hi = a_i.
REQ-023 Signed DIV of the most negative value by -1 SHALL give lo = most negative value and hi = 0.
REQ-024 annul_i in MUL or DIV SHALL return to IDLE at that edge, leave HI/LO unchanged, and not assert ready_o.
REQ-025 annul_i in IDLE or DONE SHALL have no effect.
REQ-026 When start_i and annul_i are both high in IDLE, annul SHALL win: nothing is accepted and stall_o is low.
REQ-027 Operands SHALL be captured at acceptance; a_i/b_i changes during the operation SHALL not affect the result.

Reset
REQ-028 While rst is low: state = IDLE, hi_o = 0, lo_o = 0, ready_o = 0, stall_o = 0, counters and divider registers = 0.
REQ-029 Reset asserted mid-operation SHALL discard the operation immediately (asynchronously) with no ready_o.
REQ-030 After rst is released, the first start_i SHALL be acceptable in the first clock cycle.

Structure
REQ-031 Op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are no-ops) and the state enum SHALL reside in shared package mdu_pkg.
REQ-032 The iterative divider SHALL be sub-module div_core (start, annul, signed, operands in; quotient, remainder, done out).
REQ-033 The multiplier and the FSM SHALL be inline in mul_div_unit.

Verification
REQ-034 DIVU a=0x00000007, b=0x00000002 -> stall_o high cycles 0..32, ready_o in cycle 33, lo=0x00000003, hi=0x00000001.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 MULT a=0xFFFFFFFF, b=2 -> ready_o in cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 DIVU a=0x12345678, b=0 -> ready_o in cycle 33, lo=0xFFFFFFFF, hi=0x12345678.
REQ-038 MTHI 0xAAAA5555, then DIV with annul_i in cycle 10 -> no ready_o, stall_o low from cycle 11, hi stays 0xAAAA5555; a new start in cycle 11 is accepted.
REQ-039 rst pulsed low in cycle 5 of a DIV -> hi_o/lo_o = 0 and stall_o = 0 immediately, with no ready_o afterwards.
